// File: rtl/dm_lsu_pkg.sv
// rtl/dm_lsu_pkg.sv - shared size/state encodings and lane-mask helpers for the data-memory LSU
package dm_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam logic [3:0] BE_NONE   = 4'b0000;
  localparam logic [3:0] BE_BYTE0  = 4'b1000;
  localparam logic [3:0] BE_HALF_H = 4'b1100;
  localparam logic [3:0] BE_HALF_L = 4'b0011;
  localparam logic [3:0] BE_WORD   = 4'b1111;

  // Big-endian lanes: byte offset 0 is the most significant lane.
  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = BE_BYTE0 >> off;
      SZ_HALF: lane_mask = off[1] ? BE_HALF_L : BE_HALF_H;
      SZ_WORD: lane_mask = BE_WORD;
      default: lane_mask = BE_NONE;
    endcase
  endfunction

  function automatic logic size_err(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: size_err = 1'b0;
      SZ_HALF: size_err = off[0];
      SZ_WORD: size_err = (off != 2'b00);
      default: size_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// rtl/dm_load_ext.sv - selects the addressed big-endian lane of a load word and extends it
module dm_load_ext
  import dm_lsu_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [width-1:0] lane_data,
  input  logic [1:0]       offset,
  input  size_e            size,
  input  logic             sign_ext,
  output logic [width-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (offset)
      2'd0:    byte_lane = lane_data[31:24];
      2'd1:    byte_lane = lane_data[23:16];
      2'd2:    byte_lane = lane_data[15:8];
      default: byte_lane = lane_data[7:0];
    endcase
    half_lane = offset[1] ? lane_data[15:0] : lane_data[31:16];

    case (size)
      SZ_BYTE: result = {{(width-8){sign_ext & byte_lane[7]}}, byte_lane};
      SZ_HALF: result = {{(width-16){sign_ext & half_lane[15]}}, half_lane};
      default: result = lane_data;
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - three-state load/store unit between a request port and a word-wide data memory
module dm_lsu
  import dm_lsu_pkg::*;
#(
  parameter int width     = 32,
  parameter int AddrWidth = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [31:0]          req_addr,
  input  logic [width-1:0]     req_wdata,
  output logic                 rsp_valid,
  output logic [width-1:0]     rsp_rdata,
  output logic                 rsp_err,
  output logic [AddrWidth-1:0] dm_addr,
  output logic [3:0]           dm_be,
  output logic [width-1:0]     dm_din,
  output logic                 dm_wr,
  input  logic [width-1:0]     dm_dout
);

  state_e               state, state_nxt;
  logic                 r_we, r_signed, r_err;
  size_e                r_size;
  logic [1:0]           r_off;
  logic [AddrWidth-1:0] r_waddr;
  logic [width-1:0]     r_wdata;
  logic                 accept, req_err;
  logic [width-1:0]     ld_data;

  assign accept  = req_valid && req_ready;
  // Errors are resolved at acceptance so ACCESS only needs one registered flag.
  assign req_err = size_err(size_e'(req_size), req_addr[1:0]) ||
                   ((req_addr >> (AddrWidth + 2)) != 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    dm_wr     = 1'b0;
    dm_be     = BE_NONE;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_nxt = ST_RESP;
        if (!r_err) begin
          dm_be = lane_mask(r_size, r_off);
          dm_wr = r_we;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
        rsp_valid = 1'b1;
        rsp_err   = r_err;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= SZ_BYTE;
      r_off    <= 2'b00;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else if (accept) begin
      r_we     <= req_we;
      r_signed <= req_signed;
      r_err    <= req_err;
      r_size   <= size_e'(req_size);
      r_off    <= req_addr[1:0];
      r_waddr  <= req_addr[AddrWidth+1:2];
      r_wdata  <= req_wdata;
    end
  end

  assign dm_addr = r_waddr;

  always_comb begin
    case (r_size)
      SZ_BYTE: dm_din = {(width/8){r_wdata[7:0]}};
      SZ_HALF: dm_din = {(width/16){r_wdata[15:0]}};
      default: dm_din = r_wdata;
    endcase
  end

  dm_load_ext #(.width(width)) u_load_ext (
    .lane_data (dm_dout),
    .offset    (r_off),
    .size      (r_size),
    .sign_ext  (r_signed),
    .result    (ld_data)
  );

  // Read data is captured once at the end of ACCESS and then held until the next access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    rsp_rdata <= '0;
    else if (state == ST_ACCESS) rsp_rdata <= (!r_we && !r_err) ? ld_data : '0;
  end

endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - directed self-checking bench for dm_lsu with a behavioural data memory
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_din, dm_dout;
  logic        dm_wr;

  logic [31:0] mem [0:1023];

  int          n_pass  = 0;
  int          n_total = 0;

  int          wr_cnt, rsp_cnt, lat;
  logic [3:0]  be_seen;
  logic [31:0] din_seen, got_rdata, hold_rdata;
  logic [9:0]  addr_seen;
  logic        got_err, rdy_access;

  always #5 clk = ~clk;

  dm_lsu #(.width(32), .AddrWidth(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din), .dm_wr(dm_wr), .dm_dout(dm_dout)
  );

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_wr) begin
      if (dm_be[3]) mem[dm_addr][31:24] <= dm_din[31:24];
      if (dm_be[2]) mem[dm_addr][23:16] <= dm_din[23:16];
      if (dm_be[1]) mem[dm_addr][15:8]  <= dm_din[15:8];
      if (dm_be[0]) mem[dm_addr][7:0]   <= dm_din[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Called on a falling edge with the DUT idle; observes four cycles after acceptance.
  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    wr_cnt = 0; rsp_cnt = 0; lat = -1; be_seen = 4'h0; din_seen = 32'h0; addr_seen = 10'h0;
    got_rdata = 32'h0; got_err = 1'b0; rdy_access = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid  = 1'b0;
        rdy_access = req_ready;
      end
      if (dm_wr) wr_cnt++;
      if (dm_be != 4'h0) begin
        be_seen = dm_be; din_seen = dm_din; addr_seen = dm_addr;
      end
      if (rsp_valid) begin
        rsp_cnt++; lat = c; got_rdata = rsp_rdata; got_err = rsp_err;
      end
    end
    hold_rdata = rsp_rdata;
  endtask

  initial begin
    int          acc, wrs, rsps, seen_rsp, seen_wr;
    logic [8:0]  rdy_mask;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_dm_wr", {31'b0, dm_wr}, 32'd0);
    chk("rst_dm_be", {28'b0, dm_be}, 32'h0);
    chk("rst_dm_addr", {22'b0, dm_addr}, 32'h0);
    chk("rst_dm_din", dm_din, 32'h0);

    xact(1'b1, 2'b10, 1'b0, 32'h010, 32'h12345678);
    chk("sw_wr_cnt", wr_cnt, 1);
    chk("sw_be", {28'b0, be_seen}, 32'hF);
    chk("sw_addr", {22'b0, addr_seen}, 32'd4);
    chk("sw_din", din_seen, 32'h12345678);
    chk("sw_err", {31'b0, got_err}, 32'd0);
    chk("sw_rdata", got_rdata, 32'h0);
    chk("sw_ready_busy", {31'b0, rdy_access}, 32'd0);

    xact(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    chk("lw_rdata", got_rdata, 32'h12345678);
    chk("lw_err", {31'b0, got_err}, 32'd0);
    chk("lw_latency", lat, 2);
    chk("lw_rsp_cnt", rsp_cnt, 1);
    chk("lw_no_wr", wr_cnt, 0);
    chk("lw_rdata_hold", hold_rdata, 32'h12345678);

    xact(1'b1, 2'b00, 1'b0, 32'h013, 32'h000000AB);
    chk("sb_be", {28'b0, be_seen}, 32'h1);
    chk("sb_din", din_seen, 32'hABABABAB);
    chk("sb_wr_cnt", wr_cnt, 1);
    xact(1'b0, 2'b00, 1'b1, 32'h013, 32'h0);
    chk("lb_signed", got_rdata, 32'hFFFFFFAB);
    xact(1'b0, 2'b00, 1'b0, 32'h013, 32'h0);
    chk("lbu", got_rdata, 32'h000000AB);
    xact(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    chk("lw_after_sb", got_rdata, 32'h123456AB);
    xact(1'b0, 2'b00, 1'b1, 32'h010, 32'h0);
    chk("lb_off0", got_rdata, 32'h00000012);

    xact(1'b1, 2'b01, 1'b0, 32'h022, 32'h00008001);
    chk("sh_be", {28'b0, be_seen}, 32'h3);
    chk("sh_din", din_seen, 32'h80018001);
    xact(1'b0, 2'b01, 1'b1, 32'h022, 32'h0);
    chk("lh_signed", got_rdata, 32'hFFFF8001);
    xact(1'b0, 2'b01, 1'b0, 32'h020, 32'h0);
    chk("lhu_off0", got_rdata, 32'h00000000);
    xact(1'b0, 2'b01, 1'b1, 32'h021, 32'h0);
    chk("lh_mis_err", {31'b0, got_err}, 32'd1);
    chk("lh_mis_rdata", got_rdata, 32'h0);
    chk("lh_mis_be", {28'b0, be_seen}, 32'h0);
    xact(1'b1, 2'b01, 1'b0, 32'h021, 32'h00001234);
    chk("sh_mis_err", {31'b0, got_err}, 32'd1);
    chk("sh_mis_no_wr", wr_cnt, 0);

    xact(1'b1, 2'b10, 1'b0, 32'h000, 32'hCAFEF00D);
    xact(1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEADBEEF);
    chk("oor_err", {31'b0, got_err}, 32'd1);
    chk("oor_no_wr", wr_cnt, 0);
    chk("oor_be", {28'b0, be_seen}, 32'h0);
    xact(1'b0, 2'b10, 1'b0, 32'h000, 32'h0);
    chk("oor_mem_kept", got_rdata, 32'hCAFEF00D);
    xact(1'b1, 2'b11, 1'b0, 32'h020, 32'hFFFFFFFF);
    chk("rsvd_err", {31'b0, got_err}, 32'd1);
    chk("rsvd_no_wr", wr_cnt, 0);
    xact(1'b0, 2'b10, 1'b0, 32'h020, 32'h0);
    chk("rsvd_mem_kept", got_rdata, 32'h00008001);
    xact(1'b0, 2'b10, 1'b0, 32'h012, 32'h0);
    chk("lw_mis_err", {31'b0, got_err}, 32'd1);

    xact(1'b1, 2'b10, 1'b0, 32'hFFC, 32'h0BADC0DE);
    chk("top_word_err", {31'b0, got_err}, 32'd0);
    chk("top_word_addr", {22'b0, addr_seen}, 32'h3FF);
    xact(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    chk("top_word_rd", got_rdata, 32'h0BADC0DE);

    // Back-to-back: req_valid stays high across three stores.
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hA0000000; req_valid = 1'b1;
    acc = 0; wrs = 0; rsps = 0; rdy_mask = 9'b0;
    for (int c = 0; c < 9; c++) begin
      rdy_mask[c] = req_ready;
      if (dm_wr) wrs++;
      if (rsp_valid) rsps++;
      if (req_ready && req_valid) acc++;
      @(negedge clk);
      if (rdy_mask[c] && req_valid) begin
        if (acc < 3) begin
          req_addr  = 32'h40 + 32'(4 * acc);
          req_wdata = 32'hA0000000 + 32'(acc);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b_ready_pattern", {23'b0, rdy_mask}, 32'b001001001);
    chk("b2b_accepts", acc, 3);
    chk("b2b_writes", wrs, 3);
    chk("b2b_rsps", rsps, 3);
    xact(1'b0, 2'b10, 1'b0, 32'h040, 32'h0);
    chk("b2b_rd0", got_rdata, 32'hA0000000);
    xact(1'b0, 2'b10, 1'b0, 32'h044, 32'h0);
    chk("b2b_rd1", got_rdata, 32'hA0000001);
    xact(1'b0, 2'b10, 1'b0, 32'h048, 32'h0);
    chk("b2b_rd2", got_rdata, 32'hA0000002);

    // Reset asserted mid-ACCESS of a store.
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h080; req_wdata = 32'h55555555; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_wr_before", {31'b0, dm_wr}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_wr_async", {31'b0, dm_wr}, 32'd0);
    chk("abort_be_async", {28'b0, dm_be}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_rsp = 0; seen_wr = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
      if (dm_wr) seen_wr++;
    end
    chk("abort_no_rsp", seen_rsp, 0);
    chk("abort_no_wr", seen_wr, 0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'h080, 32'h0);
    chk("abort_mem_kept", got_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
